// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, x/y counters, delayed sync/blank
// x/y lead the syncs by PIPE_DLY pixels so the image pipeline output lines up at the DAC.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic       vga_clk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W:0]   DIV_HALF = (DIV_W + 1)'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                pix_en_q, pix_en_d;
  logic                vga_clk_q, vga_clk_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic                line_start_q, line_start_d;
  logic                frame_start_q, frame_start_d;
  logic [PIPE_DLY-1:0] hs_dly_q, hs_dly_d;
  logic [PIPE_DLY-1:0] vs_dly_q, vs_dly_d;
  logic [PIPE_DLY-1:0] bl_dly_q, bl_dly_d;

  logic x_wrap, y_wrap;
  logic hs_raw, vs_raw, bl_raw;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + 1'b1;
    pix_en_d  = (div_cnt_q == DIV_MAX);
    // Written as (cnt + 1) > half so CLK_DIV=1 yields a constant 1 without a >= 0 compare.
    vga_clk_d = (({1'b0, div_cnt_d} + 1'b1) > DIV_HALF);

    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);

    hs_raw = !((x_q >= HS_START) && (x_q < HS_END));
    vs_raw = !((y_q >= VS_START) && (y_q < VS_END));
    bl_raw = (x_q < H_ACT) && (y_q < V_ACT);

    x_d      = x_q;
    y_d      = y_q;
    hs_dly_d = hs_dly_q;
    vs_dly_d = vs_dly_q;
    bl_dly_d = bl_dly_q;
    if (pix_en_q) begin
      x_d = x_wrap ? '0 : x_q + 10'd1;
      if (x_wrap) begin
        y_d = y_wrap ? '0 : y_q + 10'd1;
      end
      hs_dly_d = (hs_dly_q << 1) | PIPE_DLY'(hs_raw);
      vs_dly_d = (vs_dly_q << 1) | PIPE_DLY'(vs_raw);
      bl_dly_d = (bl_dly_q << 1) | PIPE_DLY'(bl_raw);
    end

    line_start_d  = pix_en_q && x_wrap;
    frame_start_d = pix_en_q && x_wrap && y_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_dly_q      <= '1;
      vs_dly_q      <= '1;
      bl_dly_q      <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_dly_q      <= hs_dly_d;
      vs_dly_q      <= vs_dly_d;
      bl_dly_q      <= bl_dly_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign vga_clk     = vga_clk_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hs_dly_q[PIPE_DLY-1];
  assign vsync       = vs_dly_q[PIPE_DLY-1];
  assign blank_n     = bl_dly_q[PIPE_DLY-1];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-reset bench with an arithmetic raster reference model
// Three instances: full 640x480 timing, and two shrunken rasters (CLK_DIV=1 and 3).
module tb_vga_timing_gen;

  localparam int A_D = 2, A_P = 2, A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2, A_VB = 33;
  localparam int B_D = 1, B_P = 1, B_HA = 20, B_HF = 3, B_HS = 4, B_HB = 5;
  localparam int B_VA = 12, B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int C_D = 3, C_P = 3, C_HA = 16, C_HF = 2, C_HS = 5, C_HB = 3;
  localparam int C_VA = 9, C_VF = 1, C_VS = 2, C_VB = 2;

  localparam int CD[3]  = '{A_D, B_D, C_D};
  localparam int CP[3]  = '{A_P, B_P, C_P};
  localparam int CHA[3] = '{A_HA, B_HA, C_HA};
  localparam int CHF[3] = '{A_HF, B_HF, C_HF};
  localparam int CHS[3] = '{A_HS, B_HS, C_HS};
  localparam int CHB[3] = '{A_HB, B_HB, C_HB};
  localparam int CVA[3] = '{A_VA, B_VA, C_VA};
  localparam int CVF[3] = '{A_VF, B_VF, C_VF};
  localparam int CVS[3] = '{A_VS, B_VS, C_VS};
  localparam int CVB[3] = '{A_VB, B_VB, C_VB};

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic       pe[3], vc[3], hs[3], vs[3], bl[3], ls[3], fs[3];
  logic [9:0] xs[3], ys[3];
  logic [26:0] obs[3];

  int  n_checks = 0;
  int  n_errors = 0;
  int  t[3];
  bit  mon_en = 1'b0;
  int  cyc = 0;
  int  hs_run[3], vs_run[3], bl_cnt[3], last_ls[3], last_fs[3], hold[3];

  always #5 clk = ~clk;

  vga_timing_gen #(.CLK_DIV(A_D), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .PIPE_DLY(A_P)) u_a (
    .clk(clk), .rst(rst_v[0]), .pix_en(pe[0]), .vga_clk(vc[0]), .x(xs[0]), .y(ys[0]),
    .hsync(hs[0]), .vsync(vs[0]), .blank_n(bl[0]), .line_start(ls[0]), .frame_start(fs[0]));

  vga_timing_gen #(.CLK_DIV(B_D), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .PIPE_DLY(B_P)) u_b (
    .clk(clk), .rst(rst_v[1]), .pix_en(pe[1]), .vga_clk(vc[1]), .x(xs[1]), .y(ys[1]),
    .hsync(hs[1]), .vsync(vs[1]), .blank_n(bl[1]), .line_start(ls[1]), .frame_start(fs[1]));

  vga_timing_gen #(.CLK_DIV(C_D), .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
    .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB), .PIPE_DLY(C_P)) u_c (
    .clk(clk), .rst(rst_v[2]), .pix_en(pe[2]), .vga_clk(vc[2]), .x(xs[2]), .y(ys[2]),
    .hsync(hs[2]), .vsync(vs[2]), .blank_n(bl[2]), .line_start(ls[2]), .frame_start(fs[2]));

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      obs[i] = {pe[i], vc[i], xs[i], ys[i], hs[i], vs[i], bl[i], ls[i], fs[i]};
    end
  end

  // Clocks elapsed since the last reset edge; the model derives everything from this.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      t[i] <= rst_v[i] ? 0 : t[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pixel index n = pixels advanced since reset; raster position is n mod frame size,
  // and the sync/blank outputs show the raster decode of pixel n-PIPE_DLY.
  function automatic logic [26:0] model(input int i, input int tt);
    int d, ht, tot, n, n0, pos, dp, px, py, qx, qy;
    logic pex, vcx, hsx, vsx, blx, lsx, fsx;
    d   = CD[i];
    ht  = CHA[i] + CHF[i] + CHS[i] + CHB[i];
    tot = ht * (CVA[i] + CVF[i] + CVS[i] + CVB[i]);
    n   = (tt >= 1) ? (tt - 1) / d : 0;
    n0  = (tt >= 2) ? (tt - 2) / d : 0;
    pex = (tt >= 1) && (tt % d == 0);
    vcx = (tt >= 1) && ((tt % d) >= d / 2);
    pos = n % tot;
    px  = pos % ht;
    py  = pos / ht;
    lsx = (n != n0) && (px == 0);
    fsx = (n != n0) && (pos == 0);
    if (n < CP[i]) begin
      hsx = 1'b1; vsx = 1'b1; blx = 1'b0;
    end else begin
      dp  = (n - CP[i]) % tot;
      qx  = dp % ht;
      qy  = dp / ht;
      hsx = !(qx >= CHA[i] + CHF[i] && qx < CHA[i] + CHF[i] + CHS[i]);
      vsx = !(qy >= CVA[i] + CVF[i] && qy < CVA[i] + CVF[i] + CVS[i]);
      blx = (qx < CHA[i]) && (qy < CVA[i]);
    end
    return {pex, vcx, px[9:0], py[9:0], hsx, vsx, blx, lsx, fsx};
  endfunction

  task automatic mon(input int i);
    int ht, tot;
    ht  = CHA[i] + CHF[i] + CHS[i] + CHB[i];
    tot = ht * (CVA[i] + CVF[i] + CVS[i] + CVB[i]);
    check($sformatf("raster%0d", i), 32'(obs[i]), 32'(model(i, t[i])));
    if (t[i] == 0) begin
      hs_run[i] = 0; vs_run[i] = 0; bl_cnt[i] = -1; last_ls[i] = -1; last_fs[i] = -1;
    end else begin
      if (!hs[i]) hs_run[i]++;
      else if (hs_run[i] > 0) begin
        check($sformatf("hs_width%0d", i), hs_run[i], CHS[i] * CD[i]);
        hs_run[i] = 0;
      end
      if (!vs[i]) vs_run[i]++;
      else if (vs_run[i] > 0) begin
        check($sformatf("vs_width%0d", i), vs_run[i], CVS[i] * ht * CD[i]);
        vs_run[i] = 0;
      end
      if (ls[i]) begin
        if (last_ls[i] >= 0) check($sformatf("ls_period%0d", i), cyc - last_ls[i], ht * CD[i]);
        last_ls[i] = cyc;
      end
      if (fs[i]) begin
        if (last_fs[i] >= 0) check($sformatf("fs_period%0d", i), cyc - last_fs[i], tot * CD[i]);
        if (bl_cnt[i] >= 0) check($sformatf("blank_cnt%0d", i), bl_cnt[i], CHA[i] * CVA[i] * CD[i]);
        last_fs[i] = cyc;
        bl_cnt[i]  = 0;
      end
      if (bl_cnt[i] >= 0 && bl[i]) bl_cnt[i]++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  task automatic reset_in_hsync(input int i, input int min_x);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(negedge clk);
      if (hs[i] === 1'b0 && xs[i] >= 10'(min_x)) ok = 1'b1;
    end
    if (!ok) begin
      check($sformatf("hsync_wait%0d", i), 32'd0, 32'd1);
    end else begin
      rst_v[i] = 1'b1;
      @(negedge clk);
      rst_v[i] = 1'b0;
      check($sformatf("rst_hsync%0d", i), 32'({xs[i], ys[i], hs[i], ls[i], fs[i]}),
            32'({10'd0, 10'd0, 1'b1, 1'b0, 1'b0}));
    end
  endtask

  initial begin
    bit ok;
    logic [9:0] x_prev;
    rst_v = 3'b111;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("reset%0d", i), 32'(obs[i]), 32'h18);
    mon_en = 1'b1;
    rst_v  = 3'b000;

    @(negedge clk);
    check("first_pix_early", 32'(pe[0]), 32'd0);
    @(negedge clk);
    check("first_pix", 32'(pe[0]), 32'd1);

    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (xs[1] == 10'(B_HA + B_HF)) ok = 1'b1;
    end
    check("hs_x_wait", 32'(ok), 32'd1);
    check("hs_pre", 32'(hs[1]), 32'd1);
    x_prev = xs[1];
    @(negedge clk);
    check("x_step", 32'(xs[1]), 32'(x_prev + 10'd1));
    check("hs_fall", 32'(hs[1]), 32'd0);

    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (hold[i] > 0) begin
          rst_v[i] = 1'b1;
          hold[i]--;
        end else begin
          rst_v[i] = 1'b0;
          if ($urandom_range(0, 2999) == 0) hold[i] = int'($urandom_range(1, 3));
        end
      end
    end
    @(negedge clk);
    rst_v = 3'b000;

    reset_in_hsync(0, 700);
    reset_in_hsync(1, $urandom_range(0, B_HA + B_HF));
    reset_in_hsync(2, 0);

    repeat (3000) @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
